// File: rtl/message_serializer_ctrl.sv
// message_serializer_ctrl: loads a parallel word and shifts out a clamped number of bits,
// MSB- or LSB-first, with ready/valid/done handshake and abort.
module message_serializer_ctrl #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = $clog2(DATA_W + 1),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              send,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic [LEN_W-1:0]  len,
    output logic              serial_out,
    output logic              valid,
    output logic              ready,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    logic [1:0]        state, state_nx;
    logic [DATA_W-1:0] shreg;
    logic [LEN_W-1:0]  cnt, eff_len;
    logic              start;

    assign eff_len = (len > MAX_LEN) ? MAX_LEN : len;
    assign start   = (state == IDLE) && send && (eff_len != '0);

    // abort wins over the last-bit transition; illegal encodings fall back to IDLE
    assign state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                      (state == SHIFT) ? (abort ? IDLE : (cnt == LEN_W'(1)) ? DONE : SHIFT) :
                      IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                shreg <= data_in;
                cnt   <= eff_len;
            end else if (state == SHIFT) begin
                shreg <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
                cnt   <= abort ? '0 : cnt - LEN_W'(1);
            end
        end
    end

    assign valid      = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign ready      = (state == IDLE);
    assign done       = (state == DONE);
    assign serial_out = valid & (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]);
endmodule

// File: tb/tb_message_serializer_ctrl.sv
// tb_message_serializer_ctrl: directed checks of an MSB-first and an LSB-first instance
// driven by shared stimulus; status packed as {valid,busy,ready,done,serial_out}.
module tb_message_serializer_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       send = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] len = 4'd0;
    logic       so_m, v_m, r_m, b_m, d_m;
    logic       so_l, v_l, r_l, b_l, d_l;
    logic [4:0] obs_m, obs_l;
    int         vecs = 0;
    int         errs = 0;

    localparam logic [4:0] ST_IDLE = 5'b00100;
    localparam logic [4:0] ST_DONE = 5'b00010;

    always #5 clk = ~clk;

    message_serializer_ctrl #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .send(send), .abort(abort), .data_in(data_in), .len(len),
        .serial_out(so_m), .valid(v_m), .ready(r_m), .busy(b_m), .done(d_m));

    message_serializer_ctrl #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .send(send), .abort(abort), .data_in(data_in), .len(len),
        .serial_out(so_l), .valid(v_l), .ready(r_l), .busy(b_l), .done(d_l));

    assign obs_m = {v_m, b_m, r_m, d_m, so_m};
    assign obs_l = {v_l, b_l, r_l, d_l, so_l};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        vecs++;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL reset_hold_m got=%b exp=%b", obs_m, ST_IDLE); end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs += 2;
            if (obs_m !== ST_IDLE) begin errs++; $display("FAIL reset_idle_m[%0d] got=%b exp=%b", i, obs_m, ST_IDLE); end
            if (obs_l !== ST_IDLE) begin errs++; $display("FAIL reset_idle_l[%0d] got=%b exp=%b", i, obs_l, ST_IDLE); end
        end
    endtask

    // pm/pl hold the expected bit sequence, first bit in position n-1
    task automatic test_msg(input logic [7:0] d, input logic [3:0] l, input int n,
                            input logic [7:0] pm, input logic [7:0] pl);
        send = 1'b1; data_in = d; len = l;
        step();
        send = 1'b0; data_in = ~d; len = 4'd1;
        for (int i = 0; i < n; i++) begin
            vecs += 2;
            if (obs_m !== {4'b1100, pm[n-1-i]}) begin errs++; $display("FAIL msg_m d=%h bit%0d got=%b exp=%b", d, i, obs_m, {4'b1100, pm[n-1-i]}); end
            if (obs_l !== {4'b1100, pl[n-1-i]}) begin errs++; $display("FAIL msg_l d=%h bit%0d got=%b exp=%b", d, i, obs_l, {4'b1100, pl[n-1-i]}); end
            step();
        end
        vecs += 2;
        if (obs_m !== ST_DONE) begin errs++; $display("FAIL done_m d=%h got=%b exp=%b", d, obs_m, ST_DONE); end
        if (obs_l !== ST_DONE) begin errs++; $display("FAIL done_l d=%h got=%b exp=%b", d, obs_l, ST_DONE); end
        step();
        vecs += 2;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL ready_m d=%h got=%b exp=%b", d, obs_m, ST_IDLE); end
        if (obs_l !== ST_IDLE) begin errs++; $display("FAIL ready_l d=%h got=%b exp=%b", d, obs_l, ST_IDLE); end
    endtask

    task automatic test_len_zero();
        send = 1'b1; data_in = 8'hFF; len = 4'd0;
        step();
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vecs += 2;
            if (obs_m !== ST_IDLE) begin errs++; $display("FAIL len0_m[%0d] got=%b exp=%b", i, obs_m, ST_IDLE); end
            if (obs_l !== ST_IDLE) begin errs++; $display("FAIL len0_l[%0d] got=%b exp=%b", i, obs_l, ST_IDLE); end
            step();
        end
    endtask

    task automatic test_abort();
        send = 1'b1; data_in = 8'hF0; len = 4'd8;
        step();
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) abort = 1'b1;
            vecs += 2;
            if (obs_m !== 5'b11001) begin errs++; $display("FAIL abort_m bit%0d got=%b exp=%b", i, obs_m, 5'b11001); end
            if (obs_l !== 5'b11000) begin errs++; $display("FAIL abort_l bit%0d got=%b exp=%b", i, obs_l, 5'b11000); end
            step();
        end
        abort = 1'b0;
        vecs += 2;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL abort_idle_m got=%b exp=%b", obs_m, ST_IDLE); end
        if (obs_l !== ST_IDLE) begin errs++; $display("FAIL abort_idle_l got=%b exp=%b", obs_l, ST_IDLE); end
        test_msg(8'h0D, 4'd4, 4, 8'b0000, 8'b1011);
        abort = 1'b1;
        step();
        abort = 1'b0;
        vecs++;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL abort_in_idle_m got=%b exp=%b", obs_m, ST_IDLE); end
    endtask

    task automatic test_async_reset();
        send = 1'b1; data_in = 8'hA5; len = 4'd8;
        step();
        send = 1'b0;
        for (int i = 0; i < 4; i++) step();
        vecs += 2;
        if (obs_m !== 5'b11000) begin errs++; $display("FAIL rst5_m got=%b exp=%b", obs_m, 5'b11000); end
        if (obs_l !== 5'b11000) begin errs++; $display("FAIL rst5_l got=%b exp=%b", obs_l, 5'b11000); end
        #2 reset_n = 1'b0;
        #1;
        vecs += 2;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL async_rst_m got=%b exp=%b", obs_m, ST_IDLE); end
        if (obs_l !== ST_IDLE) begin errs++; $display("FAIL async_rst_l got=%b exp=%b", obs_l, ST_IDLE); end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vecs += 2;
            if (obs_m !== ST_IDLE) begin errs++; $display("FAIL post_rst_m[%0d] got=%b exp=%b", i, obs_m, ST_IDLE); end
            if (obs_l !== ST_IDLE) begin errs++; $display("FAIL post_rst_l[%0d] got=%b exp=%b", i, obs_l, ST_IDLE); end
        end
        test_msg(8'h81, 4'd8, 8, 8'b10000001, 8'b10000001);
    endtask

    task automatic test_back_to_back();
        send = 1'b1; data_in = 8'h03; len = 4'd2;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                vecs += 2;
                if (obs_m !== 5'b11000) begin errs++; $display("FAIL b2b_m msg%0d bit%0d got=%b exp=%b", k, i, obs_m, 5'b11000); end
                if (obs_l !== 5'b11001) begin errs++; $display("FAIL b2b_l msg%0d bit%0d got=%b exp=%b", k, i, obs_l, 5'b11001); end
                step();
            end
            vecs += 2;
            if (obs_m !== ST_DONE) begin errs++; $display("FAIL b2b_done_m msg%0d got=%b exp=%b", k, obs_m, ST_DONE); end
            if (obs_l !== ST_DONE) begin errs++; $display("FAIL b2b_done_l msg%0d got=%b exp=%b", k, obs_l, ST_DONE); end
            step();
            vecs++;
            if (obs_l !== ST_IDLE) begin errs++; $display("FAIL b2b_idle_l msg%0d got=%b exp=%b", k, obs_l, ST_IDLE); end
            step();
        end
        send = 1'b0;
        step();
        step();
        step();
        vecs++;
        if (obs_m !== ST_IDLE) begin errs++; $display("FAIL b2b_end_m got=%b exp=%b", obs_m, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_msg(8'hA5, 4'd8, 8, 8'b10100101, 8'b10100101);
        test_msg(8'h0D, 4'd4, 4, 8'b0000, 8'b1011);
        test_msg(8'hFF, 4'd12, 8, 8'hFF, 8'hFF);
        test_msg(8'hB4, 4'd3, 3, 8'b101, 8'b001);
        test_len_zero();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
